scc68070_irq_ctrl: RTL and testbench



---
 rtl/scc68070_pkg.sv | 45 ++++
 rtl/scc68070_irq_ctrl_if.sv | 35 +++
 rtl/irq_edge_latch.sv | 34 +++
 rtl/scc68070_irq_ctrl.sv | 160 ++++++++++++++++
 tb/tb_scc68070_irq_ctrl.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/scc68070_pkg.sv
// rtl/scc68070_pkg.sv - shared types and constants for the SCC68070 interrupt controller
package scc68070_pkg;

   localparam int unsigned ONCHIP_VEC_BASE_DEF = 56;
   localparam int unsigned AUTOVEC_BASE_DEF    = 24;
   localparam int          NUM_INT_SRC         = 6;

   typedef struct packed {
      logic [2:0] int1_lvl;
      logic [2:0] int2_lvl;
   } lir_t;

   typedef struct packed {
      logic [2:0] i2c_lvl;
      logic [2:0] timer_lvl;
   } picr1_t;

   typedef struct packed {
      logic [2:0] uart_rx_lvl;
      logic [2:0] uart_tx_lvl;
   } picr2_t;

   // Values 0..5 double as bit positions in ack_src and as the tie-break order.
   typedef enum logic [2:0] {
      SRC_TIMER   = 3'd0,
      SRC_UART_RX = 3'd1,
      SRC_UART_TX = 3'd2,
      SRC_I2C     = 3'd3,
      SRC_INT1    = 3'd4,
      SRC_INT2    = 3'd5,
      SRC_EXT     = 3'd6,
      SRC_NONE    = 3'd7
   } src_e;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RESOLVE = 2'd1,
      ST_HOLD    = 2'd2
   } state_e;

   function automatic logic [7:0] vec_of(input int unsigned base, input logic [2:0] lvl);
      return 8'(base) + {5'd0, lvl};
   endfunction

endpackage

// File: rtl/scc68070_irq_ctrl_if.sv
// rtl/scc68070_irq_ctrl_if.sv - request, register and acknowledge signals of the interrupt controller
interface scc68070_irq_ctrl_if;
   logic       timer_irq;
   logic       uart_rx_irq;
   logic       uart_tx_irq;
   logic       i2c_irq;
   logic       int1n;
   logic       int2n;
   logic       in2;
   logic       in4;
   logic       in5;
   logic       reg_wr;
   logic [1:0] reg_rd_sel;
   logic [7:0] reg_wdata;
   logic [7:0] reg_rdata;
   logic       iack;
   logic [2:0] iack_level;
   logic [2:0] ipl;
   logic [7:0] vec;
   logic       vec_valid;
   logic       autovector;
   logic [5:0] ack_src;

   modport master (
      output timer_irq, uart_rx_irq, uart_tx_irq, i2c_irq, int1n, int2n, in2, in4, in5,
      output reg_wr, reg_rd_sel, reg_wdata, iack, iack_level,
      input  reg_rdata, ipl, vec, vec_valid, autovector, ack_src
   );

   modport slave (
      input  timer_irq, uart_rx_irq, uart_tx_irq, i2c_irq, int1n, int2n, in2, in4, in5,
      input  reg_wr, reg_rd_sel, reg_wdata, iack, iack_level,
      output reg_rdata, ipl, vec, vec_valid, autovector, ack_src
   );
endinterface

// File: rtl/irq_edge_latch.sv
// rtl/irq_edge_latch.sv - synchronises an active-low request and latches its falling edge
module irq_edge_latch (
   input  logic clk,
   input  logic nReset,
   input  logic i_irq_n,
   input  logic i_enable,
   input  logic i_clr,
   output logic o_pend
);
   logic r_sync1;
   logic r_sync2;
   logic r_sync3;
   logic r_pend;
   logic w_fall;

   // r_sync3 only remembers the previous synchronised level for edge detection.
   assign w_fall = r_sync3 & ~r_sync2 & i_enable;

   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
         r_sync3 <= 1'b1;
         r_pend  <= 1'b0;
      end else begin
         r_sync1 <= i_irq_n;
         r_sync2 <= r_sync1;
         r_sync3 <= r_sync2;
         r_pend  <= w_fall | (r_pend & ~i_clr);
      end
   end

   assign o_pend = r_pend;
endmodule

// File: rtl/scc68070_irq_ctrl.sv
// rtl/scc68070_irq_ctrl.sv - level registers, priority arbitration and IACK sequencing
module scc68070_irq_ctrl
   import scc68070_pkg::*;
#(
   parameter int unsigned ONCHIP_VEC_BASE = ONCHIP_VEC_BASE_DEF,
   parameter int unsigned AUTOVEC_BASE    = AUTOVEC_BASE_DEF
) (
   input  logic                 clk,
   input  logic                 nReset,
   scc68070_irq_ctrl_if.slave   bus
);
   lir_t                              r_lir;
   picr1_t                            r_picr1;
   picr2_t                            r_picr2;
   state_e                            r_state;
   state_e                            w_next;
   src_e                              r_src;
   src_e                              w_win_src;
   logic [2:0]                        r_lvl;
   logic [2:0]                        r_ipl;
   logic [2:0]                        w_max_lvl;
   logic [7:0]                        r_vec;
   logic                              r_autovec;
   logic [5:0]                        w_ack_src;
   logic [7:0]                        w_rdata;
   logic                              w_int1_pend;
   logic                              w_int2_pend;
   logic [NUM_INT_SRC-1:0]            w_req;
   logic [NUM_INT_SRC-1:0][2:0]       w_lvl;
   logic                              w_unused_wdata;

   assign w_unused_wdata = bus.reg_wdata[7] ^ bus.reg_wdata[3];

   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         r_lir   <= '0;
         r_picr1 <= '0;
         r_picr2 <= '0;
      end else if (bus.reg_wr) begin
         case (bus.reg_rd_sel)
            2'd0:    r_lir   <= lir_t'({bus.reg_wdata[6:4], bus.reg_wdata[2:0]});
            2'd1:    r_picr1 <= picr1_t'(bus.reg_wdata[5:0]);
            2'd2:    r_picr2 <= picr2_t'(bus.reg_wdata[5:0]);
            default: ;
         endcase
      end
   end

   always_comb begin
      w_rdata = 8'h00;
      case (bus.reg_rd_sel)
         2'd0:    w_rdata = {1'b0, r_lir.int1_lvl, 1'b0, r_lir.int2_lvl};
         2'd1:    w_rdata = {2'b00, r_picr1};
         2'd2:    w_rdata = {2'b00, r_picr2};
         default: w_rdata = 8'h00;
      endcase
   end

   irq_edge_latch u_int1 (
      .clk      (clk),
      .nReset   (nReset),
      .i_irq_n  (bus.int1n),
      .i_enable (r_lir.int1_lvl != 3'd0),
      .i_clr    ((r_state == ST_RESOLVE) && (r_src == SRC_INT1)),
      .o_pend   (w_int1_pend)
   );

   irq_edge_latch u_int2 (
      .clk      (clk),
      .nReset   (nReset),
      .i_irq_n  (bus.int2n),
      .i_enable (r_lir.int2_lvl != 3'd0),
      .i_clr    ((r_state == ST_RESOLVE) && (r_src == SRC_INT2)),
      .o_pend   (w_int2_pend)
   );

   // Index i of w_req/w_lvl is source i of src_e.
   assign w_req = {w_int2_pend, w_int1_pend, bus.i2c_irq, bus.uart_tx_irq,
                   bus.uart_rx_irq, bus.timer_irq};
   assign w_lvl = {r_lir.int2_lvl, r_lir.int1_lvl, r_picr1.i2c_lvl, r_picr2.uart_tx_lvl,
                   r_picr2.uart_rx_lvl, r_picr1.timer_lvl};

   always_comb begin
      w_max_lvl = bus.in5 ? 3'd5 : bus.in4 ? 3'd4 : bus.in2 ? 3'd2 : 3'd0;
      for (int i = 0; i < NUM_INT_SRC; i++) begin
         if (w_req[i] && (w_lvl[i] > w_max_lvl)) w_max_lvl = w_lvl[i];
      end
   end

   // Descending scan so the lowest index (highest tie priority) is written last.
   always_comb begin
      w_win_src = SRC_NONE;
      if (bus.iack_level != 3'd0) begin
         if ((bus.in5 && bus.iack_level == 3'd5) || (bus.in4 && bus.iack_level == 3'd4) ||
             (bus.in2 && bus.iack_level == 3'd2))
            w_win_src = SRC_EXT;
         for (int i = NUM_INT_SRC - 1; i >= 0; i--) begin
            if (w_req[i] && (w_lvl[i] == bus.iack_level)) w_win_src = src_e'(3'(i));
         end
      end
   end

   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) r_state <= ST_IDLE;
      else         r_state <= w_next;
   end

   always_comb begin
      w_next    = r_state;
      w_ack_src = 6'd0;
      case (r_state)
         ST_IDLE:    if (bus.iack) w_next = ST_RESOLVE;
         ST_RESOLVE: begin
            w_next = ST_HOLD;
            if ((r_src != SRC_EXT) && (r_src != SRC_NONE)) w_ack_src = 6'd1 << r_src;
         end
         ST_HOLD:    if (!bus.iack) w_next = ST_IDLE;
         default:    w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         r_ipl     <= 3'd0;
         r_src     <= SRC_NONE;
         r_lvl     <= 3'd0;
         r_vec     <= 8'd0;
         r_autovec <= 1'b0;
      end else begin
         r_ipl <= w_max_lvl;
         if ((r_state == ST_IDLE) && bus.iack) begin
            r_src <= w_win_src;
            r_lvl <= bus.iack_level;
         end
         if (r_state == ST_RESOLVE) begin
            case (r_src)
               SRC_EXT: begin
                  r_vec     <= vec_of(AUTOVEC_BASE, r_lvl);
                  r_autovec <= 1'b1;
               end
               SRC_NONE: begin
                  r_vec     <= 8'(AUTOVEC_BASE);
                  r_autovec <= 1'b0;
               end
               default: begin
                  r_vec     <= vec_of(ONCHIP_VEC_BASE, r_lvl);
                  r_autovec <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.reg_rdata  = w_rdata;
   assign bus.ipl        = r_ipl;
   assign bus.vec        = r_vec;
   assign bus.vec_valid  = (r_state == ST_HOLD);
   assign bus.autovector = r_autovec;
   assign bus.ack_src    = w_ack_src;
endmodule

// File: tb/tb_scc68070_irq_ctrl.sv
// tb/tb_scc68070_irq_ctrl.sv - scoreboard bench for the SCC68070 interrupt controller
module tb_scc68070_irq_ctrl;
   typedef struct {
      logic [7:0] vec;
      logic       av;
      logic [5:0] ack;
   } exp_t;

   logic clk;
   logic nReset;
   int   tests;
   int   fails;
   exp_t exp_q[$];

   scc68070_irq_ctrl_if bus_if ();

   scc68070_irq_ctrl dut (
      .clk    (clk),
      .nReset (nReset),
      .bus    (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_reg(input logic [1:0] sel, input logic [7:0] data, input logic [7:0] rb);
      bus_if.reg_rd_sel = sel;
      bus_if.reg_wdata  = data;
      bus_if.reg_wr     = 1'b1;
      tick();
      bus_if.reg_wr     = 1'b0;
      check($sformatf("readback_sel%0d", sel), bus_if.reg_rdata, rb);
   endtask

   task automatic do_ack(input logic [2:0] lvl, input logic [7:0] v, input logic av,
                         input logic [5:0] ack, input logic mid_in5);
      exp_t e;
      e.vec = v;
      e.av  = av;
      e.ack = ack;
      exp_q.push_back(e);
      bus_if.iack_level = lvl;
      bus_if.iack       = 1'b1;
      tick();
      check("vec_valid_lat1", bus_if.vec_valid, 0);
      if (mid_in5) bus_if.in5 = 1'b1;
      tick();
      check("vec_valid_lat2", bus_if.vec_valid, 1);
      if (mid_in5) check("ipl_mid_ack", bus_if.ipl, 5);
      bus_if.iack = 1'b0;
      tick();
      tick();
   endtask

   // Monitor: records the acknowledge pulse, then checks it with the vector on vec_valid rise.
   initial begin
      logic [5:0] seen_ack;
      int         ack_cycles;
      logic       prev_vv;
      exp_t       e;
      seen_ack   = 6'd0;
      ack_cycles = 0;
      prev_vv    = 1'b0;
      forever begin
         @(negedge clk);
         if (!nReset) begin
            seen_ack   = 6'd0;
            ack_cycles = 0;
            prev_vv    = 1'b0;
         end else begin
            if (bus_if.ack_src != 6'd0) begin
               seen_ack = bus_if.ack_src;
               ack_cycles++;
            end
            if (bus_if.vec_valid && !prev_vv) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_vector", 1, 0);
               end else begin
                  e = exp_q.pop_front();
                  check("vec", bus_if.vec, e.vec);
                  check("autovector", bus_if.autovector, e.av);
                  check("ack_src", seen_ack, e.ack);
                  check("ack_cycles", ack_cycles, (e.ack != 6'd0) ? 1 : 0);
               end
               seen_ack   = 6'd0;
               ack_cycles = 0;
            end
            prev_vv = bus_if.vec_valid;
         end
      end
   end

   initial begin
      tests = 0;
      fails = 0;
      nReset = 1'b0;
      bus_if.timer_irq = 0; bus_if.uart_rx_irq = 0; bus_if.uart_tx_irq = 0; bus_if.i2c_irq = 0;
      bus_if.int1n = 1; bus_if.int2n = 1;
      bus_if.in2 = 0; bus_if.in4 = 0; bus_if.in5 = 0;
      bus_if.reg_wr = 0; bus_if.reg_rd_sel = 2'd0; bus_if.reg_wdata = 8'h00;
      bus_if.iack = 0; bus_if.iack_level = 3'd0;
      tick();
      tick();
      check("rst_ipl", bus_if.ipl, 0);
      check("rst_vec", bus_if.vec, 0);
      check("rst_vec_valid", bus_if.vec_valid, 0);
      check("rst_autovector", bus_if.autovector, 0);
      check("rst_ack_src", bus_if.ack_src, 0);
      check("rst_lir", bus_if.reg_rdata, 0);
      nReset = 1'b1;
      tick();

      // Timer at level 6
      write_reg(2'd1, 8'h06, 8'h06);
      bus_if.timer_irq = 1;
      check("ipl_timer_before", bus_if.ipl, 0);
      tick();
      check("ipl_timer", bus_if.ipl, 6);
      do_ack(3'd6, 8'd62, 1'b0, 6'b000001, 1'b0);
      bus_if.timer_irq = 0;
      tick();
      check("ipl_timer_clear", bus_if.ipl, 0);

      // INT1 edge at level 5
      write_reg(2'd0, 8'h50, 8'h50);
      bus_if.int1n = 0;
      tick(); tick(); tick();
      check("ipl_int1_3cyc", bus_if.ipl, 0);
      tick();
      check("ipl_int1_4cyc", bus_if.ipl, 5);
      bus_if.int1n = 1;
      do_ack(3'd5, 8'd61, 1'b0, 6'b010000, 1'b0);
      check("ipl_int1_cleared", bus_if.ipl, 0);

      // External level 4
      bus_if.in4 = 1;
      tick();
      check("ipl_in4", bus_if.ipl, 4);
      do_ack(3'd4, 8'd28, 1'b1, 6'b000000, 1'b0);
      bus_if.in4 = 0;

      // Level 5 tie: timer > uart_rx > external
      write_reg(2'd1, 8'h05, 8'h05);
      write_reg(2'd2, 8'h28, 8'h28);
      bus_if.timer_irq = 1; bus_if.uart_rx_irq = 1; bus_if.in5 = 1;
      tick();
      check("ipl_tie", bus_if.ipl, 5);
      do_ack(3'd5, 8'd61, 1'b0, 6'b000001, 1'b0);
      bus_if.timer_irq = 0;
      do_ack(3'd5, 8'd61, 1'b0, 6'b000010, 1'b0);
      bus_if.uart_rx_irq = 0;
      do_ack(3'd5, 8'd29, 1'b1, 6'b000000, 1'b0);
      bus_if.in5 = 0;

      // Spurious acknowledge and disabled INT2
      do_ack(3'd3, 8'd24, 1'b0, 6'b000000, 1'b0);
      write_reg(2'd0, 8'h00, 8'h00);
      bus_if.int2n = 0;
      tick(); tick(); tick(); tick(); tick();
      check("ipl_int2_disabled", bus_if.ipl, 0);
      bus_if.int2n = 1;
      tick();
      write_reg(2'd0, 8'h03, 8'h03);
      tick(); tick();
      check("ipl_int2_no_pend", bus_if.ipl, 0);
      write_reg(2'd0, 8'h00, 8'h00);

      // Higher request mid-ack raises ipl but keeps the captured vector
      write_reg(2'd1, 8'h02, 8'h02);
      bus_if.timer_irq = 1;
      tick();
      check("ipl_timer2", bus_if.ipl, 2);
      do_ack(3'd2, 8'd58, 1'b0, 6'b000001, 1'b1);
      bus_if.in5 = 0;
      bus_if.timer_irq = 0;
      tick();

      // Reset during HOLD
      write_reg(2'd1, 8'h06, 8'h06);
      bus_if.timer_irq = 1;
      tick();
      bus_if.iack_level = 3'd6;
      bus_if.iack = 1;
      tick();
      tick();
      check("hold_vec_valid", bus_if.vec_valid, 1);
      check("hold_vec", bus_if.vec, 62);
      nReset = 1'b0;
      #1;
      check("rst_hold_vec_valid", bus_if.vec_valid, 0);
      check("rst_hold_vec", bus_if.vec, 0);
      check("rst_hold_ipl", bus_if.ipl, 0);
      check("rst_hold_ack", bus_if.ack_src, 0);
      bus_if.iack = 0;
      bus_if.timer_irq = 0;
      tick();
      nReset = 1'b1;
      tick();
      bus_if.reg_rd_sel = 2'd0; #1 check("rb_lir_after_rst", bus_if.reg_rdata, 0);
      bus_if.reg_rd_sel = 2'd1; #1 check("rb_picr1_after_rst", bus_if.reg_rdata, 0);
      bus_if.reg_rd_sel = 2'd2; #1 check("rb_picr2_after_rst", bus_if.reg_rdata, 0);
      write_reg(2'd3, 8'hFF, 8'h00);
      bus_if.reg_rd_sel = 2'd1; #1 check("rb_picr1_after_resv", bus_if.reg_rdata, 0);

      for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
      check("scoreboard_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
